// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scanner.
// Patterns are active-high and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  typedef logic [1:0] digit_idx_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_decode.sv
// BCD digit to active-high 7-segment pattern; non-BCD codes show a dash.
module seven_seg_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   pattern_c
);

  always_comb begin
    pattern_c = SEG_DASH;
    if (blank) begin
      pattern_c = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    pattern_c = SEG_0;
        4'd1:    pattern_c = SEG_1;
        4'd2:    pattern_c = SEG_2;
        4'd3:    pattern_c = SEG_3;
        4'd4:    pattern_c = SEG_4;
        4'd5:    pattern_c = SEG_5;
        4'd6:    pattern_c = SEG_6;
        4'd7:    pattern_c = SEG_7;
        4'd8:    pattern_c = SEG_8;
        4'd9:    pattern_c = SEG_9;
        default: pattern_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with snapshot load,
// optional leading-zero blanking and selectable output polarity.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLANK_LEADING = 1,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DIGIT_W-1:0]    thousands,
  input  logic [DIGIT_W-1:0]    hundreds,
  input  logic [DIGIT_W-1:0]    tens,
  input  logic [DIGIT_W-1:0]    ones,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [SEG_W-1:0]      seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // XOR masks double as the all-off pattern and the polarity inversion
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [SEG_W-1:0]      SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0]      cnt;
  digit_idx_t            idx;
  logic [DIGIT_W-1:0]    d3, d2, d1, d0;

  logic [DIGIT_W-1:0]    digit_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      pattern_c;
  logic [NUM_DIGITS-1:0] onehot_c;

  // Refresh counter, digit index and snapshot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      d3  <= '0;
      d2  <= '0;
      d1  <= '0;
      d0  <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        d3 <= thousands;
        d2 <= hundreds;
        d1 <= tens;
        d0 <= ones;
      end
    end
  end

  // Select the active digit and decide whether it is a leading zero
  always_comb begin
    digit_c = d0;
    blank_c = 1'b0;
    case (idx)
      2'd3: begin
        digit_c = d3;
        blank_c = (d3 == 4'd0);
      end
      2'd2: begin
        digit_c = d2;
        blank_c = (d3 == 4'd0) && (d2 == 4'd0);
      end
      2'd1: begin
        digit_c = d1;
        blank_c = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      default: begin
        digit_c = d0;
        blank_c = 1'b0;
      end
    endcase
    if (BLANK_LEADING == 0) begin
      blank_c = 1'b0;
    end
    onehot_c = 4'b0001 << idx;
  end

  seven_seg_decode u_decode (
    .digit     (digit_c),
    .blank     (blank_c),
    .pattern_c (pattern_c)
  );

  // Pin registers with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      anode <= ANODE_OFF;
      seg   <= SEG_OFF;
    end else begin
      anode <= onehot_c ^ ANODE_OFF;
      seg   <= pattern_c ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: three parameterisations driven in parallel,
// a cycle scoreboard plus directed dwell checks.
module tb_seven_seg_scanner;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] thousands = 4'd0, hundreds = 4'd0, tens = 4'd0, ones = 4'd0;

  logic [3:0] anode_al, anode_ah, anode_nb;
  logic [6:0] seg_al, seg_ah, seg_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_al), .seg(seg_al));
  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1), .ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_ah), .seg(seg_ah));
  seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(0), .ACTIVE_LOW(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_nb), .seg(seg_nb));

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
    logic [6:0] sg_nb;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] lut(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // digits packed as {d3,d2,d1,d0}
  function automatic logic [6:0] model_seg(input logic [15:0] dg, input int pos, input bit bl);
    logic [3:0] d;
    bit lead;
    d = dg[pos*4 +: 4];
    lead = 1'b1;
    for (int p = 3; p >= pos; p--) if (dg[p*4 +: 4] != 4'd0) lead = 1'b0;
    if (bl && pos != 0 && lead) return 7'h00;
    return lut(d);
  endfunction

  logic [15:0] m_dig = '0;
  int          m_cnt = 0;
  int          m_pos = 0;

  // Reference model: predicts the pin values produced by this edge
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e.an = 4'h0; e.sg = 7'h00; e.sg_nb = 7'h00;
      sb.push_back(e);
      m_dig <= '0;
      m_cnt <= 0;
      m_pos <= 0;
    end else begin
      e.an    = 4'(1 << m_pos);
      e.sg    = model_seg(m_dig, m_pos, 1'b1);
      e.sg_nb = model_seg(m_dig, m_pos, 1'b0);
      sb.push_back(e);
      if (load) m_dig <= {thousands, hundreds, tens, ones};
      if (m_cnt == int'(DIV) - 1) begin
        m_cnt <= 0;
        m_pos <= (m_pos + 1) % 4;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Scoreboard checker
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 4;
      assert (anode_ah === e.an && seg_ah === e.sg) else begin
        errors++;
        $error("FAIL sb_ah: got an=%b seg=%h, want an=%b seg=%h", anode_ah, seg_ah, e.an, e.sg);
      end
      assert (anode_al === ~e.an && seg_al === ~e.sg) else begin
        errors++;
        $error("FAIL sb_al: got an=%b seg=%h, want an=%b seg=%h", anode_al, seg_al, ~e.an, ~e.sg);
      end
      assert (anode_nb === e.an) else begin
        errors++;
        $error("FAIL sb_nb_an: got %b, want %b", anode_nb, e.an);
      end
      assert (seg_nb === e.sg_nb) else begin
        errors++;
        $error("FAIL sb_nb_seg: got %h, want %h", seg_nb, e.sg_nb);
      end
    end
  end

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    thousands = a; hundreds = b; tens = c; ones = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Waits for a fresh dwell on anode an (active-high bench view), then checks all 4 cycles
  task automatic dwell(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic [6:0] sgnb);
    int n;
    n = 0;
    while (anode_ah === an && n < 40) begin @(negedge clk); n++; end
    while (anode_ah !== an && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; errors++;
      $error("FAIL %s_timeout: anode %b never seen, last %b", tag, an, anode_ah);
    end else begin
      for (int k = 0; k < int'(DIV); k++) begin
        chk({tag, "_an"}, {7'h0, anode_ah}, {7'h0, an});
        chk({tag, "_seg"}, {4'h0, seg_ah}, {4'h0, sg});
        chk({tag, "_nb"}, {4'h0, seg_nb}, {4'h0, sgnb});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    // Reset held 3 cycles, active-low instance shows all-off
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_al", {anode_al, seg_al}, {4'b1111, 7'h7F});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_d0", {anode_al, seg_al}, {4'b1110, 7'h40});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_d1", {anode_al, seg_al}, {4'b1101, 7'h7F});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_d2", {anode_al, seg_al}, {4'b1011, 7'h7F});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_d3", {anode_al, seg_al}, {4'b0111, 7'h7F});
    end

    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    for (int r = 0; r < 2; r++) begin
      dwell("scan_d0", 4'b0001, 7'h66, 7'h66);
      dwell("scan_d1", 4'b0010, 7'h4F, 7'h4F);
      dwell("scan_d2", 4'b0100, 7'h5B, 7'h5B);
      dwell("scan_d3", 4'b1000, 7'h06, 7'h06);
    end

    do_load(4'd0, 4'd0, 4'd4, 4'd2);
    dwell("blk1_d3", 4'b1000, 7'h00, 7'h3F);
    dwell("blk1_d0", 4'b0001, 7'h5B, 7'h5B);
    dwell("blk1_d1", 4'b0010, 7'h66, 7'h66);
    dwell("blk1_d2", 4'b0100, 7'h00, 7'h3F);

    do_load(4'd0, 4'd5, 4'd0, 4'd0);
    dwell("blk2_d3", 4'b1000, 7'h00, 7'h3F);
    dwell("blk2_d0", 4'b0001, 7'h3F, 7'h3F);
    dwell("blk2_d1", 4'b0010, 7'h3F, 7'h3F);
    dwell("blk2_d2", 4'b0100, 7'h6D, 7'h6D);

    do_load(4'd0, 4'd0, 4'hA, 4'd0);
    dwell("inv_d1", 4'b0010, 7'h40, 7'h40);
    dwell("inv_d2", 4'b0100, 7'h00, 7'h3F);
    dwell("inv_d3", 4'b1000, 7'h00, 7'h3F);
    dwell("inv_d0", 4'b0001, 7'h3F, 7'h3F);

    // Load during the 2nd cycle of the index-1 dwell
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    while (anode_ah !== 4'b0001) @(negedge clk);
    while (anode_ah !== 4'b0010) @(negedge clk);
    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("mid_e1", {anode_ah, seg_ah}, {4'b0010, 7'h4F});
    @(negedge clk);
    chk("mid_e2", {anode_ah, seg_ah}, {4'b0010, 7'h07});
    @(negedge clk);
    chk("mid_e3", {anode_ah, seg_ah}, {4'b0010, 7'h07});
    @(negedge clk);
    chk("mid_e4", {anode_ah, seg_ah}, {4'b0100, 7'h7D});

    // One-cycle reset while index 2 is on the pins
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ah", {anode_ah, seg_ah}, {4'b0000, 7'h00});
    chk("mrst_al", {anode_al, seg_al}, {4'b1111, 7'h7F});
    @(negedge clk);
    chk("mrst_idx0", {anode_ah, seg_ah}, {4'b0001, 7'h3F});
    dwell("mrst_d1", 4'b0010, 7'h00, 7'h3F);
    dwell("mrst_d2", 4'b0100, 7'h00, 7'h3F);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
